// File: rtl/mx2_sweep_pkg.sv
// Shared types and golden model for the CC_MX2 sweep sequencer/checker.
package mx2_sweep_pkg;

    localparam int Y_W = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_NEXT,
        ST_DONE
    } sweep_state_t;

    // Expected y bus for one {s,d1,d0} input vector across all four mux groups:
    // bit 0 is the fully dynamic mux, bits 1-2 hold s constant (0 / 1) with live
    // data, bits 3-6 tie the data to constants with live select, and bits 7-14
    // are the all-constant muxes enumerated by their 3-bit tie-off code.
    function automatic logic [Y_W-1:0] mx2_exp(input logic s, input logic d1, input logic d0);
        logic [Y_W-1:0] y;
        logic [1:0]     i2;
        logic [2:0]     i3;
        y    = '0;
        y[0] = s ? d1 : d0;
        y[1] = d0;
        y[2] = d1;
        for (int i = 0; i < 4; i++) begin
            i2       = 2'(i);
            y[3 + i] = s ? i2[1] : i2[0];
        end
        for (int i = 0; i < 8; i++) begin
            i3       = 3'(i);
            y[7 + i] = i3[2] ? i3[1] : i3[0];
        end
        return y;
    endfunction

endpackage

// File: rtl/mx2_sweep_golden.sv
// Combinational golden reference for the 15-bit CC_MX2 y bus.
module mx2_sweep_golden
    import mx2_sweep_pkg::*;
(
    input  logic           s,
    input  logic           d1,
    input  logic           d0,
    output logic [Y_W-1:0] y
);

    // Pure lookup of the expected y for the vector currently applied.
    always_comb begin
        y = mx2_exp(s, d1, d0);
    end

endmodule

// File: rtl/mx2_sweep_ctrl.sv
// Sweep sequencer/checker for CC_MX2: drives all 8 {s,d1,d0} vectors, waits a
// settle window, compares y against the golden model and reports the outcome.
// Optional build macro MX2_SWEEP_GRAY_EN: vectors are issued in Gray order
// (one input toggles per step); otherwise plain binary order.
module mx2_sweep_ctrl
    import mx2_sweep_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int PASSES     = 1,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_d0,
    output logic             dut_d1,
    output logic             dut_s,
    input  logic [Y_W-1:0]   dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       err_vec,
    output logic [Y_W-1:0]   err_mask
);

    localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
    localparam int PASS_W   = $clog2(PASSES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [PASS_W-1:0]   PASS_LAST   = PASS_W'(PASSES - 1);

    sweep_state_t         state_q;
    sweep_state_t         state_d;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic [2:0]           idx;
    logic [PASS_W-1:0]    pass_cnt;
    logic                 last_vec;
    logic [Y_W-1:0]       exp_y;
    logic [Y_W-1:0]       mism;

    // Vector order for a given sweep index.
    function automatic logic [2:0] vec_of(input logic [2:0] i);
`ifdef MX2_SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    // Error counter sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + ERR_W'(1);
    endfunction

    mx2_sweep_golden u_golden (
        .s  (dut_s),
        .d1 (dut_d1),
        .d0 (dut_d0),
        .y  (exp_y)
    );

    // Mismatch bits and end-of-run detection.
    always_comb begin
        mism     = exp_y ^ dut_y;
        last_vec = (idx == 3'd7) && (pass_cnt == PASS_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_DRIVE;
            ST_DRIVE:  state_d = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_NEXT;
            ST_NEXT:   state_d = last_vec ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Counters, driven vector, error capture and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            idx        <= '0;
            pass_cnt   <= '0;
            dut_s      <= 1'b0;
            dut_d1     <= 1'b0;
            dut_d0     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            err_vec    <= '0;
            err_mask   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        err_cnt  <= '0;
                        err_vec  <= '0;
                        err_mask <= '0;
                        idx      <= '0;
                        pass_cnt <= '0;
                    end
                end
                ST_DRIVE: begin
                    {dut_s, dut_d1, dut_d0} <= vec_of(idx);
                    settle_cnt              <= '0;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + SETTLE_W'(1);
                end
                ST_SAMPLE: begin
                    if (|mism) begin
                        err_cnt <= sat_inc(err_cnt);
                        // err_cnt only grows during a run, so zero means first miss.
                        if (err_cnt == '0) begin
                            err_vec  <= {dut_s, dut_d1, dut_d0};
                            err_mask <= mism;
                        end
                    end
                end
                ST_NEXT: begin
                    idx <= idx + 3'd1;
                    if (idx == 3'd7 && !last_vec) begin
                        pass_cnt <= pass_cnt + PASS_W'(1);
                    end
                    if (last_vec) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_cnt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
